instr_fetch_ctrl: RTL

Fetch sequencer for the SIMD processor's instruction register file. It drives the combinational-read PC into the instruction store and registers the returned word into a one-entry instruction buffer. It hands instructions to decode/execute over a valid/ready handshake, supports a jump redirect from execute, and stops on a HALT opcode. The processor is started and restarted with a START pulse.

---
 rtl/instr_fetch_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: drives PC into a combinational instruction store and buffers one word for decode.
// Latency: START -> PC 0 after one edge, first word valid after the next; jump target valid one bubble later.
// Backpressure: a full buffer with INSTR_READY low stalls PC and buffer; no word is refetched or lost.
module instr_fetch_ctrl #(
  parameter int               N       = 512,
  parameter int               OPC_W   = 4,
  parameter logic [OPC_W-1:0] HALT_OP = 4'h6,
  parameter int               CNT_W   = 16,
  localparam int              PCW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  output logic [PCW-1:0]   PC_AXI,
  input  logic [31:0]      INSTR_AXI,
  output logic [31:0]      INSTR,
  output logic             INSTR_VALID,
  input  logic             INSTR_READY,
  input  logic             JUMP_EN,
  input  logic [PCW-1:0]   JUMP_ADDR,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] ISSUE_CNT
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [PCW-1:0] PC_LAST = PCW'(N - 1);

  state_t           state_q, state_d;
  logic [PCW-1:0]   pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             xfer;
  logic             buf_free;
  logic             is_halt;
  logic [PCW-1:0]   pc_inc;
  logic [31:0]      jaddr_ext;
  logic [PCW-1:0]   jump_tgt;

  // Handshake, buffer occupancy, opcode decode and PC arithmetic
  always_comb begin
    xfer      = vld_q & INSTR_READY;
    buf_free  = ~vld_q | INSTR_READY;
    is_halt   = (INSTR_AXI[OPC_W-1:0] == HALT_OP);
    pc_inc    = (pc_q == PC_LAST) ? '0 : pc_q + PCW'(1);
    // Targets beyond the store (only possible for non-power-of-2 depth) restart at 0
    jaddr_ext = 32'(JUMP_ADDR);
    jump_tgt  = (jaddr_ext >= 32'(N)) ? '0 : JUMP_ADDR;
  end

  // Next-state and datapath update; jump outranks capture and HALT detection
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    vld_d   = vld_q;
    cnt_d   = xfer ? cnt_q + CNT_W'(1) : cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_d = S_FETCH;
          pc_d    = '0;
          vld_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      S_FETCH: begin
        if (JUMP_EN) begin
          // Buffered word is squashed; if it transfers this cycle it is already counted
          pc_d  = jump_tgt;
          vld_d = 1'b0;
        end else if (buf_free) begin
          instr_d = INSTR_AXI;
          vld_d   = 1'b1;
          if (is_halt) begin
            state_d = S_DRAIN;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      S_DRAIN: begin
        if (JUMP_EN) begin
          state_d = S_FETCH;
          pc_d    = jump_tgt;
          vld_d   = 1'b0;
        end else if (xfer) begin
          state_d = S_DONE;
          vld_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PC_AXI      = pc_q;
  assign INSTR       = instr_q;
  assign INSTR_VALID = vld_q;
  assign ISSUE_CNT   = cnt_q;
  assign BUSY        = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign DONE        = (state_q == S_DONE);

endmodule
